traffic_timer: RTL and testbench



---
 rtl/traffic_timer.sv | 99 +++++++++
 tb/tb_traffic_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_timer.sv
//-----------------------------------------------------------------------------
// traffic_timer : prescaled timebase issuing short/long terminal-count pulses
//                 to the traffic-light controller.
// Optional build macro: TRAFFIC_TIMER_FAST_SIM_EN (prescaler removed).
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module traffic_timer #(
   parameter int PRESCALE = 1,
   parameter int N_SHORT  = 2,
   parameter int N_LONG   = 10,
   parameter int CW       = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          RST_Q,
   input  logic          EN,
   output logic          TICK,
   output logic          TC_2,
   output logic          TC_10,
   output logic [CW-1:0] CNT_10
);

   localparam int SW = $clog2(N_SHORT);
   localparam logic [SW-1:0] SHORT_MAX = SW'(N_SHORT - 1);
   localparam logic [CW-1:0] LONG_MAX  = CW'(N_LONG - 1);

   generate
      if (PRESCALE < 1 || PRESCALE > 65535) begin : g_chk_prescale
         $error("traffic_timer: PRESCALE out of range 1..65535");
      end
      if (N_SHORT < 2) begin : g_chk_short
         $error("traffic_timer: N_SHORT must be >= 2");
      end
      if (N_LONG < 2 || N_LONG > (1 << CW)) begin : g_chk_long
         $error("traffic_timer: N_LONG must be in 2..2^CW");
      end
   endgenerate

   logic [SW-1:0] short_cnt;
   logic [CW-1:0] long_cnt;
   logic          tick_int;

`ifdef TRAFFIC_TIMER_FAST_SIM_EN
   assign tick_int = EN;
`else
   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
   logic [15:0] pre_cnt;
   assign tick_int = EN && (pre_cnt == PRE_MAX);
`endif

   always_ff @(posedge CLK) begin
      if (RST || RST_Q) begin
`ifndef TRAFFIC_TIMER_FAST_SIM_EN
         pre_cnt <= '0;
`endif
         short_cnt <= '0;
         long_cnt  <= '0;
         TICK      <= 1'b0;
         TC_2      <= 1'b0;
         TC_10     <= 1'b0;
      end else if (!EN) begin
         // Freeze: counts hold, but pulses never stretch across it.
         TICK  <= 1'b0;
         TC_2  <= 1'b0;
         TC_10 <= 1'b0;
      end else begin
`ifndef TRAFFIC_TIMER_FAST_SIM_EN
         pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 16'd1;
`endif
         TICK <= tick_int;
         if (tick_int) begin
            if (short_cnt < SHORT_MAX) begin
               short_cnt <= short_cnt + 1'b1;
               TC_2      <= 1'b0;
            end else begin
               short_cnt <= '0;
               TC_2      <= 1'b1;
            end
            if (long_cnt < LONG_MAX) begin
               long_cnt <= long_cnt + 1'b1;
               TC_10    <= 1'b0;
            end else begin
               long_cnt <= '0;
               TC_10    <= 1'b1;
            end
         end else begin
            TC_2  <= 1'b0;
            TC_10 <= 1'b0;
         end
      end
   end

   assign CNT_10 = long_cnt;

endmodule

`default_nettype wire

// File: tb/tb_traffic_timer.sv
//-----------------------------------------------------------------------------
// tb_traffic_timer : scoreboard bench for traffic_timer (PRESCALE=1 and 4).
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tb_traffic_timer;

   localparam int CW = 4;
   localparam int NS = 2;
   localparam int NL = 10;
`ifdef TRAFFIC_TIMER_FAST_SIM_EN
   localparam int P4_EFF = 1;
`else
   localparam int P4_EFF = 4;
`endif

   typedef logic [CW+2:0] vec_t;   // {TICK, TC_2, TC_10, CNT_10}

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          RST_Q = 1'b0;
   logic          EN = 1'b0;
   logic          tick_a, tc2_a, tc10_a, tick_b, tc2_b, tc10_b;
   logic [CW-1:0] cnt_a, cnt_b;

   vec_t qa[$];
   vec_t qb[$];
   int   compared = 0;
   int   mismatched = 0;
   int   ph[2] = '{0, 0};
   int   tk[2] = '{0, 0};
   int   pre_eff[2] = '{1, P4_EFF};

   traffic_timer #(.PRESCALE(1), .N_SHORT(NS), .N_LONG(NL), .CW(CW)) dut_a (
      .CLK(CLK), .RST(RST), .RST_Q(RST_Q), .EN(EN),
      .TICK(tick_a), .TC_2(tc2_a), .TC_10(tc10_a), .CNT_10(cnt_a));

   traffic_timer #(.PRESCALE(4), .N_SHORT(NS), .N_LONG(NL), .CW(CW)) dut_b (
      .CLK(CLK), .RST(RST), .RST_Q(RST_Q), .EN(EN),
      .TICK(tick_b), .TC_2(tc2_b), .TC_10(tc10_b), .CNT_10(cnt_b));

   always #5 CLK = ~CLK;

   // Reference: enabled-cycle phase and absolute tick count since the last clear.
   function automatic vec_t model(input int i, input logic r, input logic rq, input logic e);
      logic t;
      if (r || rq) begin
         ph[i] = 0;
         tk[i] = 0;
         return '0;
      end
      if (!e) return {3'b000, CW'(tk[i] % NL)};
      t = (ph[i] == pre_eff[i] - 1);
      ph[i] = (ph[i] + 1) % pre_eff[i];
      if (t) tk[i]++;
      return {t, t && (tk[i] % NS == 0), t && (tk[i] % NL == 0), CW'(tk[i] % NL)};
   endfunction

   task automatic cycle(input logic r, input logic rq, input logic e,
                        output vec_t ga, output vec_t ea, output vec_t gb, output vec_t eb);
      RST = r; RST_Q = rq; EN = e;
      qa.push_back(model(0, r, rq, e));
      qb.push_back(model(1, r, rq, e));
      @(posedge CLK); #1;
      ga = {tick_a, tc2_a, tc10_a, cnt_a};
      gb = {tick_b, tc2_b, tc10_b, cnt_b};
      ea = qa.pop_front();
      eb = qb.pop_front();
   endtask

   task automatic test_reset();
      vec_t ga, ea, gb, eb;
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b0, 1'b1, ga, ea, gb, eb);
         compared += 2;
         if (ga !== ea) begin mismatched++; $display("FAIL reset_a: got %h expected %h", ga, ea); end
         if (gb !== eb) begin mismatched++; $display("FAIL reset_b: got %h expected %h", gb, eb); end
      end
   endtask

   task automatic test_count();
      vec_t ga, ea, gb, eb;
      int   first10 = -1;
      for (int k = 1; k <= 30; k++) begin
         cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
         compared++;
         if (ga !== ea) begin mismatched++; $display("FAIL count k=%0d: got %h expected %h", k, ga, ea); end
         if (ga[CW] === 1'b1 && first10 < 0) first10 = k;
         if (k == 10) begin
            compared++;
            if (ga[CW+1:CW] !== 2'b11) begin
               mismatched++; $display("FAIL count_both_tc: got %b expected 11", ga[CW+1:CW]);
            end
         end
      end
      compared++;
      if (first10 !== 10) begin mismatched++; $display("FAIL count_first_tc10: got %0d expected 10", first10); end
   endtask

   task automatic test_prescale();
      vec_t ga, ea, gb, eb;
      int   first2 = -1, first10 = -1;
      cycle(1'b1, 1'b0, 1'b1, ga, ea, gb, eb);
      for (int k = 1; k <= 10 * P4_EFF + 5; k++) begin
         cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
         compared++;
         if (gb !== eb) begin mismatched++; $display("FAIL prescale k=%0d: got %h expected %h", k, gb, eb); end
         if (gb[CW+1] === 1'b1 && first2 < 0) first2 = k;
         if (gb[CW] === 1'b1 && first10 < 0) first10 = k;
      end
      compared += 2;
      if (first2 !== 2 * P4_EFF) begin
         mismatched++; $display("FAIL prescale_first_tc2: got %0d expected %0d", first2, 2 * P4_EFF);
      end
      if (first10 !== 10 * P4_EFF) begin
         mismatched++; $display("FAIL prescale_first_tc10: got %0d expected %0d", first10, 10 * P4_EFF);
      end
   endtask

   task automatic test_rstq_mid();
      vec_t ga, ea, gb, eb;
      int   first10 = -1;
      cycle(1'b1, 1'b0, 1'b1, ga, ea, gb, eb);
      for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
      compared++;
      if (ga[CW-1:0] !== 4'd6) begin mismatched++; $display("FAIL rstq_mid_pre: got %0d expected 6", ga[CW-1:0]); end
      cycle(1'b0, 1'b1, 1'b1, ga, ea, gb, eb);
      compared++;
      if (ga !== ea) begin mismatched++; $display("FAIL rstq_mid_clear: got %h expected %h", ga, ea); end
      for (int k = 1; k <= 12; k++) begin
         cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
         compared++;
         if (ga !== ea) begin mismatched++; $display("FAIL rstq_mid k=%0d: got %h expected %h", k, ga, ea); end
         if (ga[CW] === 1'b1 && first10 < 0) first10 = k;
      end
      compared++;
      if (first10 !== 10) begin mismatched++; $display("FAIL rstq_mid_tc10: got %0d expected 10", first10); end
   endtask

   task automatic test_rstq_wrap();
      vec_t ga, ea, gb, eb;
      cycle(1'b1, 1'b0, 1'b1, ga, ea, gb, eb);
      for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
      compared++;
      if (ga[CW-1:0] !== 4'd9) begin mismatched++; $display("FAIL rstq_wrap_pre: got %0d expected 9", ga[CW-1:0]); end
      cycle(1'b0, 1'b1, 1'b1, ga, ea, gb, eb);
      compared += 2;
      if (ga[CW] !== 1'b0 || ga[CW-1:0] !== '0) begin
         mismatched++; $display("FAIL rstq_wrap: got tc10=%b cnt=%0d expected tc10=0 cnt=0", ga[CW], ga[CW-1:0]);
      end
      if (ga !== ea) begin mismatched++; $display("FAIL rstq_wrap_sb: got %h expected %h", ga, ea); end
   endtask

   task automatic test_freeze();
      vec_t ga, ea, gb, eb;
      int   first10 = -1;
      cycle(1'b1, 1'b0, 1'b1, ga, ea, gb, eb);
      for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 1'b0, 1'b0, ga, ea, gb, eb);
         compared += 2;
         if (ga !== {3'b000, 4'd3}) begin mismatched++; $display("FAIL freeze_hold: got %h expected 03", ga); end
         if (gb !== eb) begin mismatched++; $display("FAIL freeze_b: got %h expected %h", gb, eb); end
      end
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
         compared++;
         if (ga !== ea) begin mismatched++; $display("FAIL freeze_run k=%0d: got %h expected %h", k, ga, ea); end
         if (ga[CW] === 1'b1 && first10 < 0) first10 = k;
      end
      compared++;
      if (first10 !== 7) begin mismatched++; $display("FAIL freeze_tc10: got %0d expected 7", first10); end
   endtask

   task automatic test_all_reset();
      vec_t ga, ea, gb, eb;
      for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, ga, ea, gb, eb);
      cycle(1'b1, 1'b1, 1'b0, ga, ea, gb, eb);
      compared += 2;
      if (ga !== '0) begin mismatched++; $display("FAIL all_reset_a: got %h expected 00", ga); end
      if (gb !== '0) begin mismatched++; $display("FAIL all_reset_b: got %h expected 00", gb); end
   endtask

   initial begin
      test_reset();
      test_count();
      test_prescale();
      test_rstq_mid();
      test_rstq_wrap();
      test_freeze();
      test_all_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
